// File: rtl/except_arbiter_pkg.sv
// Shared CP0 exception encodings, MEM-stage exception flag positions and
// arbiter FSM encoding, plus the fixed-priority event selector.
package except_arbiter_pkg;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_TR   = 5'd13;

   // Bit positions inside mem_exc_i
   localparam int EXC_BIT_ADEL_IF = 7;
   localparam int EXC_BIT_RI      = 6;
   localparam int EXC_BIT_SYS     = 5;
   localparam int EXC_BIT_BP      = 4;
   localparam int EXC_BIT_OV      = 3;
   localparam int EXC_BIT_TR      = 2;
   localparam int EXC_BIT_ADEL_LD = 1;
   localparam int EXC_BIT_ADES    = 0;

   // Status register fields
   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_REDIRECT = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic       valid;
      logic       is_eret;
      logic [4:0] code;
      logic       badv_we;
      logic       badv_fetch;  // BadVAddr comes from the fetch address, not the data address
   } exc_evt_t;

   function automatic exc_evt_t select_event(input logic       int_pend,
                                             input logic [7:0] exc,
                                             input logic       eret);
      exc_evt_t e;
      e         = '0;
      e.valid   = 1'b1;
      if (int_pend) begin
         e.code = EXC_INT;
      end else if (exc[EXC_BIT_ADEL_IF]) begin
         e.code       = EXC_ADEL;
         e.badv_we    = 1'b1;
         e.badv_fetch = 1'b1;
      end else if (exc[EXC_BIT_RI]) begin
         e.code = EXC_RI;
      end else if (exc[EXC_BIT_SYS]) begin
         e.code = EXC_SYS;
      end else if (exc[EXC_BIT_BP]) begin
         e.code = EXC_BP;
      end else if (exc[EXC_BIT_OV]) begin
         e.code = EXC_OV;
      end else if (exc[EXC_BIT_TR]) begin
         e.code = EXC_TR;
      end else if (exc[EXC_BIT_ADEL_LD]) begin
         e.code    = EXC_ADEL;
         e.badv_we = 1'b1;
      end else if (exc[EXC_BIT_ADES]) begin
         e.code    = EXC_ADES;
         e.badv_we = 1'b1;
      end else if (eret) begin
         e.is_eret = 1'b1;
      end else begin
         e.valid = 1'b0;
      end
      return e;
   endfunction

endpackage

// File: rtl/except_arbiter_int_sync.sv
// Two-flop synchronizer bringing asynchronous interrupt lines into clk.
module int_sync #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/except_arbiter.sv
// MEM-stage exception/interrupt arbiter: picks the highest-priority event,
// commits it to CP0 for one cycle, flushes the pipe, then redirects fetch.
module except_arbiter
   import except_arbiter_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [5:0]  int_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_bd_i,
   input  logic [7:0]  mem_exc_i,
   input  logic        mem_eret_i,
   input  logic [31:0] mem_badvaddr_i,
   input  logic [31:0] mem_fetch_addr_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_exccode_o,
   output logic [31:0] cp0_epc_o,
   output logic        cp0_epc_we_o,
   output logic        cp0_bd_o,
   output logic        cp0_badv_we_o,
   output logic [31:0] cp0_badvaddr_o,
   output logic        cp0_eret_o,
   output logic [5:0]  ip_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   input  logic        redirect_ready_i
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   logic       int_pend;
   exc_evt_t   evt;
   logic       unused_inputs;

   arb_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
   logic        epc_we_q, epc_we_d;
   logic        bd_q, bd_d;
   logic        badv_we_q, badv_we_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic        eret_q, eret_d;
   logic        flush_q, flush_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rpc_q, rpc_d;

   int_sync #(.WIDTH(6)) u_int_sync (
      .clk    (clk),
      .resetn (resetn),
      .d_i    (int_i),
      .q_o    (ip_o)
   );

   // IM[7:0] lines up with {IP[7:2] from the synchronizer, software IP[1:0]}
   assign int_pend = (|({ip_o, cause_i[9:8]} & status_i[15:8]))
                     && status_i[STATUS_IE] && !status_i[STATUS_EXL];
   assign evt      = select_event(int_pend, mem_exc_i, mem_eret_i);

   assign unused_inputs = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = 1'b0;
      exccode_d  = exccode_q;
      epc_d      = epc_q;
      epc_we_d   = 1'b0;
      bd_d       = bd_q;
      badv_we_d  = 1'b0;
      badvaddr_d = badvaddr_q;
      eret_d     = 1'b0;
      flush_d    = flush_q;
      rvalid_d   = rvalid_q;
      rpc_d      = rpc_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_valid_i && evt.valid) begin
               state_d = ST_COMMIT;
               flush_d = 1'b1;
               if (evt.is_eret) begin
                  eret_d = 1'b1;
                  rpc_d  = epc_i;
               end else begin
                  we_d      = 1'b1;
                  exccode_d = evt.code;
                  epc_d     = mem_bd_i ? (mem_pc_i - 32'd4) : mem_pc_i;
                  bd_d      = mem_bd_i;
                  // A nested exception must not clobber the outer EPC/BD
                  epc_we_d  = !status_i[STATUS_EXL];
                  badv_we_d = evt.badv_we;
                  if (evt.badv_we) begin
                     badvaddr_d = evt.badv_fetch ? mem_fetch_addr_i : mem_badvaddr_i;
                  end
                  rpc_d = EXC_VECTOR;
               end
            end
         end
         ST_COMMIT: begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
         end
         ST_FLUSH: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d  = ST_REDIRECT;
               cnt_d    = 4'd0;
               flush_d  = 1'b0;
               rvalid_d = 1'b1;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready_i) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            flush_d  = 1'b0;
            rvalid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         we_q       <= 1'b0;
         exccode_q  <= 5'd0;
         epc_q      <= 32'd0;
         epc_we_q   <= 1'b0;
         bd_q       <= 1'b0;
         badv_we_q  <= 1'b0;
         badvaddr_q <= 32'd0;
         eret_q     <= 1'b0;
         flush_q    <= 1'b0;
         rvalid_q   <= 1'b0;
         rpc_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         exccode_q  <= exccode_d;
         epc_q      <= epc_d;
         epc_we_q   <= epc_we_d;
         bd_q       <= bd_d;
         badv_we_q  <= badv_we_d;
         badvaddr_q <= badvaddr_d;
         eret_q     <= eret_d;
         flush_q    <= flush_d;
         rvalid_q   <= rvalid_d;
         rpc_q      <= rpc_d;
      end
   end

   assign cp0_we_o         = we_q;
   assign cp0_exccode_o    = exccode_q;
   assign cp0_epc_o        = epc_q;
   assign cp0_epc_we_o     = epc_we_q;
   assign cp0_bd_o         = bd_q;
   assign cp0_badv_we_o    = badv_we_q;
   assign cp0_badvaddr_o   = badvaddr_q;
   assign cp0_eret_o       = eret_q;
   assign flush_o          = flush_q;
   assign redirect_valid_o = rvalid_q;
   assign redirect_pc_o    = rpc_q;

endmodule
